hex_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits on the CHIP-8 board. It accepts a packed hex value through a valid/ready load port and holds it in a one-deep pending slot. New values are committed only at frame boundaries, so a frame never mixes old and new digits. The controller walks the digits with a blank gap between them to suppress ghosting, and drives active-low segment and digit-enable lines.

---
 rtl/hex_scan_pkg.sv | 38 +++
 rtl/hex_scan_ctrl_if.sv | 28 ++
 rtl/hex_seg_decode.sv | 17 +
 rtl/hex_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/hex_scan_pkg.sv
// Shared definitions for the hex scan controller.
//   scan_state_e   : scan FSM states (blank gap, digit drive)
//   SEG_OFF        : active-low "all segments off" pattern
//   SEG_TABLE      : hex nibble -> active-low segments, bit6..0 = g,f,e,d,c,b,a
//   lz_blank_mask  : leading-zero blank mask helper (used when
//                    HEX_LEADING_ZERO_BLANK_EN is defined)
package hex_scan_pkg;

    typedef enum logic [0:0] {
        StBlank,
        StDrive
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry 15 first, entry 0 last (packed array, index = nibble value).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Sets bit i for every digit above the most significant non-zero nibble.
    // Digit 0 is never included, so a value of zero still shows "0".
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] data, input int num_digits);
        logic       seen;
        logic [7:0] mask;
        seen = 1'b0;
        mask = '0;
        for (int i = 7; i >= 1; i--) begin
            if (i < num_digits) begin
                if (data[4*i +: 4] != 4'h0) seen = 1'b1;
                if (!seen) mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Load port of the hex scan controller (valid/ready).
//   load_valid : requester presents load_data/load_blank
//   load_ready : controller pending slot is empty
//   load_data  : packed nibbles, nibble i shown on digit i
//   load_blank : per-digit force-blank mask, 1 = dark
// Modports: master = requester, slave = controller.
interface hex_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [NUM_DIGITS-1:0]     load_blank;

    modport master (
        output load_valid,
        output load_data,
        output load_blank,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_blank,
        output load_ready
    );
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   blank  : 1 forces all segments off
//   seg_n  : active-low segments, bit6..0 = g,f,e,d,c,b,a
module hex_seg_decode
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = blank ? SEG_OFF : SEG_TABLE[nibble];
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// A value accepted on the load port waits in a one-deep pending slot and is
// committed to the display registers only on entry to the blank gap of
// digit 0, so a frame never mixes old and new digits.
//   Clk, Reset : clock, synchronous active-high reset
//   load       : valid/ready load port (hex_scan_ctrl_if.slave)
//   seg_n      : active-low segments, bit6..0 = g,f,e,d,c,b,a
//   dig_n      : active-low digit enables, at most one low
//   frame_tick : one-cycle pulse on the first blank cycle of digit 0
// Optional: define HEX_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    hex_scan_ctrl_if.slave        load,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_tick
);

    localparam int unsigned MaxPhase = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int unsigned CntW     = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;
    localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW    = 4 * NUM_DIGITS;

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic                    pend_full_q, pend_full_d;
    logic [DataW-1:0]        pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [DataW-1:0]        disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    tick_q, tick_d;

    logic                    frame_start;
    logic                    commit;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   commit_blank;
    logic [6:0]              dec_seg;

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [7:0]              lz_full;
`endif

    // Next digit's decoded pattern; display registers never change on the
    // edge that enters DRIVE, so reading the current copy is safe.
    hex_seg_decode u_decode (
        .nibble (disp_data_q[4*idx_d +: 4]),
        .blank  (disp_blank_q[idx_d]),
        .seg_n  (dec_seg)
    );

    // Scan FSM next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CntW'(1);
        unique case (state_q)
            StBlank: begin
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    state_d = StDrive;
                    cnt_d   = '0;
                end
            end
            StDrive: begin
                if (cnt_q == CntW'(SCAN_DIV - 1)) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
                end
            end
        endcase
    end

    // Pending slot, commit and registered outputs
    always_comb begin
        frame_start = (state_q == StDrive) && (state_d == StBlank) && (idx_d == '0);
        commit      = frame_start && pend_full_q;
        // Ready is low while full, so accept and commit are mutually exclusive.
        accept      = load.load_valid && !pend_full_q;

`ifdef HEX_LEADING_ZERO_BLANK_EN
        lz_full      = lz_blank_mask(32'(pend_data_q), int'(NUM_DIGITS));
        commit_blank = pend_blank_q | lz_full[NUM_DIGITS-1:0];
`else
        commit_blank = pend_blank_q;
`endif

        pend_full_d  = pend_full_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        if (commit) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d  = 1'b1;
            pend_data_d  = load.load_data;
            pend_blank_d = load.load_blank;
        end

        disp_data_d  = commit ? pend_data_q : disp_data_q;
        disp_blank_d = commit ? commit_blank : disp_blank_q;

        seg_d  = SEG_OFF;
        dig_d  = '1;
        if (state_d == StDrive) begin
            seg_d        = dec_seg;
            dig_d[idx_d] = 1'b0;
        end
        tick_d = frame_start;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StBlank;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            disp_data_q  <= '0;
            disp_blank_q <= '1;
            seg_q        <= SEG_OFF;
            dig_q        <= '1;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            tick_q       <= tick_d;
        end
    end

    assign load.load_ready = ~pend_full_q;
    assign seg_n           = seg_q;
    assign dig_n           = dig_q;
    assign frame_tick      = tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4,
// GAP_CYCLES=2 (24-cycle frame). Inputs change at negedge or posedge+1,
// outputs are sampled at negedge.
module tb_hex_scan_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
    logic       frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    hex_scan_ctrl_if #(.NUM_DIGITS(4)) ifc ();

    hex_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .GAP_CYCLES (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (ifc),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] exp;   // expected seg_n per digit, [0] = digit 0
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // From one negedge to the next; drops load_valid once a transfer happens.
    task automatic next_cycle();
        logic acc;
        acc = ifc.load_valid && ifc.load_ready;
        @(posedge Clk);
        #1;
        if (acc) ifc.load_valid = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40 && !frame_tick; i++) next_cycle();
        chk("wait_tick", 32'(frame_tick), 32'd1);
    endtask

    // Checks one full frame starting on its frame_tick cycle; ends on the
    // first cycle of the following frame.
    task automatic check_frame(input string name, input logic [3:0][6:0] exp);
        for (int c = 0; c < 24; c++) begin
            int         d;
            logic [3:0] onehot;
            logic [3:0] exp_dig;
            logic [6:0] exp_seg;
            d      = c / 6;
            onehot = 4'b0001 << d;
            if ((c % 6) >= 2) begin
                exp_dig = ~onehot;
                exp_seg = exp[d];
            end else begin
                exp_dig = 4'hF;
                exp_seg = 7'h7F;
            end
            chk({name, " dig_n"}, 32'(dig_n), 32'(exp_dig));
            chk({name, " seg_n"}, 32'(seg_n), 32'(exp_seg));
            chk({name, " frame_tick"}, 32'(frame_tick), 32'(c == 0));
            next_cycle();
        end
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] blank);
        for (int i = 0; i < 40 && !ifc.load_ready; i++) next_cycle();
        chk("load ready before", 32'(ifc.load_ready), 32'd1);
        ifc.load_data  = data;
        ifc.load_blank = blank;
        ifc.load_valid = 1'b1;
        next_cycle();
        chk("load ready after accept", 32'(ifc.load_ready), 32'd0);
        chk("load valid dropped", 32'(ifc.load_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{data: 16'h12AF, blank: 4'b0000, exp: {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{data: 16'h0000, blank: 4'b0101, exp: {7'h40, 7'h7F, 7'h40, 7'h7F}};
`ifdef HEX_LEADING_ZERO_BLANK_EN
        vecs[2] = '{data: 16'h00A0, blank: 4'b0000, exp: {7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[4] = '{data: 16'h0567, blank: 4'b0000, exp: {7'h7F, 7'h12, 7'h02, 7'h78}};
`else
        vecs[2] = '{data: 16'h00A0, blank: 4'b0000, exp: {7'h40, 7'h40, 7'h08, 7'h40}};
        vecs[4] = '{data: 16'h0567, blank: 4'b0000, exp: {7'h40, 7'h12, 7'h02, 7'h78}};
`endif
        vecs[3] = '{data: 16'h8F3C, blank: 4'b1000, exp: {7'h7F, 7'h0E, 7'h30, 7'h46}};
        vecs[5] = '{data: 16'hBDE9, blank: 4'b0010, exp: {7'h03, 7'h21, 7'h7F, 7'h10}};

        Reset          = 1'b1;
        ifc.load_valid = 1'b0;
        ifc.load_data  = '0;
        ifc.load_blank = '0;
        repeat (3) @(negedge Clk);

        chk("reset seg_n", 32'(seg_n), 32'h7F);
        chk("reset dig_n", 32'(dig_n), 32'hF);
        chk("reset load_ready", 32'(ifc.load_ready), 32'd1);
        chk("reset frame_tick", 32'(frame_tick), 32'd0);

        // No load: display mask resets all-dark, digit enables still walk.
        Reset = 1'b0;
        wait_tick();
        chk("idle load_ready", 32'(ifc.load_ready), 32'd1);
        check_frame("dark", {4{7'h7F}});
        chk("tick period", 32'(frame_tick), 32'd1);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].data, vecs[v].blank);
            wait_tick();
            chk("ready after commit", 32'(ifc.load_ready), 32'd1);
            check_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Second load stalls until the first is committed; no mixed frame.
        load(16'h1111, 4'b0000);
        ifc.load_data  = 16'h2222;
        ifc.load_blank = 4'b0000;
        ifc.load_valid = 1'b1;
        next_cycle();
        chk("stall ready low", 32'(ifc.load_ready), 32'd0);
        chk("stall valid held", 32'(ifc.load_valid), 32'd1);
        wait_tick();
        check_frame("stall 1111", {4{7'h79}});
        check_frame("stall 2222", {4{7'h24}});
        chk("stall valid dropped", 32'(ifc.load_valid), 32'd0);

        // Reset during DRIVE of digit 2 with a pending load discards it.
        load(16'h3333, 4'b0000);
        for (int i = 0; i < 40 && dig_n != 4'b1011; i++) next_cycle();
        chk("reach digit2", 32'(dig_n), 32'hB);
        Reset = 1'b1;
        next_cycle();
        chk("midreset dig_n", 32'(dig_n), 32'hF);
        chk("midreset seg_n", 32'(seg_n), 32'h7F);
        chk("midreset load_ready", 32'(ifc.load_ready), 32'd1);
        chk("midreset frame_tick", 32'(frame_tick), 32'd0);
        Reset = 1'b0;
        wait_tick();
        check_frame("post reset dark", {4{7'h7F}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
